// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO between MEM stage and data memory with load-hazard detection
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  output logic        st_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [2:0]  dm_size,
  output logic [31:0] dm_pc,
  output logic        empty
);

  localparam int            PW    = $clog2(DEPTH);
  localparam logic [PW:0]   FULL  = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW:0]   C_ONE = (PW+1)'(1);

  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [2:0]    r_size [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          r_err;

  logic          w_ready;
  logic          w_aligned;
  logic          w_enq;
  logic          w_hit;
  logic          w_hazard;
  logic          w_drain;
  logic [PW-1:0] w_off;

  assign w_ready = (r_count != FULL);
  assign w_enq   = st_valid && w_ready && w_aligned;

  // Alignment rule per size code; illegal codes never align
  always_comb begin
    case (st_size)
      3'b000:  w_aligned = (st_addr[1:0] == 2'b00);
      3'b001:  w_aligned = ~st_addr[0];
      3'b010:  w_aligned = 1'b1;
      default: w_aligned = 1'b0;
    endcase
  end

  // Compare the load word index against every live slot (head .. tail-1)
  always_comb begin
    w_hit = 1'b0;
    w_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if (({1'b0, w_off} < r_count) && (r_addr[i][AW+1:2] == ld_addr[AW+1:2]))
        w_hit = 1'b1;
    end
  end

  // A stalled load gives the port back so the hitting store can drain
  assign w_hazard = ld_valid && w_hit;
  assign w_drain  = (r_count != '0) && (!ld_valid || w_hazard);

  // Pointer, occupancy and error-pulse bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= st_valid && w_ready && !w_aligned;
      if (w_enq)
        r_tail <= r_tail + P_ONE;
      if (w_drain)
        r_head <= r_head + P_ONE;
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload capture; contents are meaningless outside the live window
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_wdata;
      r_size[r_tail] <= st_size;
      r_pc[r_tail]   <= st_pc;
    end
  end

  assign st_ready  = w_ready;
  assign st_err    = r_err;
  assign ld_hazard = w_hazard;
  assign empty     = (r_count == '0);
  assign dm_we     = w_drain;
  assign dm_addr   = w_drain ? r_addr[r_head] : ld_addr;
  assign dm_wd     = w_drain ? r_data[r_head] : 32'h0;
  assign dm_size   = w_drain ? r_size[r_head] : 3'b000;
  assign dm_pc     = w_drain ? r_pc[r_head]   : 32'h0;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the MEM-stage access logic and the data memory.
- Queues stores (address, data, size code, PC) in a FIFO and drains them to the DM write port one per cycle whenever the port is not taken by a load.
- Detects loads that hit a pending store to the same word and raises a hazard so the pipeline stalls until the buffer has drained that word.
- Rejects misaligned stores with a registered error pulse.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- AW, 10, word-index width compared for hazards (address bits [AW+1:2]).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- st_valid  input  1  CPU requests a store this cycle
- st_addr  input  32  store byte address
- st_wdata  input  32  store data (right-aligned for half/byte)
- st_size  input  3  000 word, 001 half, 010 byte (the DM's store encoding); other codes are illegal
- st_pc  input  32  PC of the store, passed through for the DM log
- st_ready  output  1  buffer can accept a store this cycle
- st_err  output  1  registered one-cycle pulse: the previous cycle's store was misaligned or had an illegal size
- ld_valid  input  1  CPU performs a load this cycle
- ld_addr  input  32  load byte address
- ld_hazard  output  1  load must be held; it hits a pending entry
- dm_we  output  1  DM write enable
- dm_addr  output  32  DM address: head entry address when draining, else ld_addr
- dm_wd  output  32  head entry data
- dm_size  output  3  head entry size code; 000 when not draining
- dm_pc  output  32  head entry PC
- empty  output  1  no pending entries

Behaviour:
- Storage: circular FIFO with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count of 0..DEPTH.
- st_ready = (count != DEPTH), evaluated on the current count. A pop in the same cycle does not free a slot early.
- Enqueue happens at posedge when st_valid && st_ready && aligned. Aligned means:
  - word: addr[1:0] == 0
  - half: addr[0] == 0
  - byte: always
  - illegal size codes are never aligned
- A misaligned or illegal store is not enqueued; st_err is 1 in the following cycle only.
- st_valid while !st_ready: store ignored, no error. The CPU must hold the request.
- ld_hazard (combinational) = ld_valid && some live entry has addr[AW+1:2] == ld_addr[AW+1:2]. Only live entries (head..tail-1) are compared; an entry being enqueued this cycle is not visible.
- drain = (count != 0) && (!ld_valid || ld_hazard). A stalled load yields the port, so a hazard cannot deadlock.
- While drain: dm_we = 1 and dm_addr/dm_wd/dm_size/dm_pc come from the head entry; head advances at posedge.
- While not draining: dm_we = 0, dm_addr = ld_addr, dm_wd = 0, dm_size = 000, dm_pc = 0.
- Simultaneous enqueue and drain: count unchanged. This is legal even when count == DEPTH-1 or count == 1.
- Drain latency: an entry enqueued at edge N can drain at the earliest in the cycle after edge N. With no loads, an empty buffer plus one store writes DM one cycle later.
- Order: stores reach the DM strictly in FIFO order. Two stores to the same word are both written, oldest first.
- Reset (checked at posedge clk):
  - head = tail = count = 0, st_err = 0, all entry valid state cleared
  - outputs after reset: st_ready = 1, empty = 1, dm_we = 0, ld_hazard = 0
  - reset mid-drain discards every pending store; no DM write occurs in the reset cycle's next state
  - reset takes priority over a simultaneous st_valid
- Entry data registers need no reset; only pointers, count and st_err are reset.

Test Plan:
- Reset, then store word 0x0000_0010 = 0xDEAD_BEEF (size 000, pc 0x3000) with no loads -> next cycle dm_we = 1, dm_addr = 0x10, dm_wd = 0xDEADBEEF, dm_pc = 0x3000; the cycle after, empty = 1, dm_we = 0.
- Hold ld_valid = 1 (addr 0x100, no hit) while issuing 4 stores to 0x0, 0x4, 0x8, 0xC -> st_ready = 0 after the 4th and a 5th store is not accepted. Drop ld_valid -> four writes in order 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- Buffer holds a byte store to 0x22 while a load hits 0x20 -> ld_hazard = 1, dm_we = 1, dm_addr = 0x22, dm_size = 010 in that cycle; next cycle ld_hazard = 0 and dm_addr = 0x20.
- Store half to 0x0000_0013 -> not enqueued, st_err = 1 for exactly one cycle, empty stays 1. Store word to 0x6 -> same result.
- count = 3 (DEPTH 4): enqueue and drain in the same cycle, repeated 6 times -> count stays 3, pointers wrap, DM sees the entries in issue order.
- Reset asserted with 2 pending entries and st_valid = 1 -> after the edge empty = 1, st_ready = 1, dm_we = 0, and no write for the discarded entries ever appears.
